// File: rtl/vga_pmod_pkg.sv
// rtl/vga_pmod_pkg.sv - VGA timing defaults, PMOD pin map and word packing for vga_pmod_tx
package vga_pmod_pkg;

  localparam int CNT_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // TinyVGA PMOD pin order on uo_out
  localparam int UO_R1    = 0;
  localparam int UO_G1    = 1;
  localparam int UO_B1    = 2;
  localparam int UO_VSYNC = 3;
  localparam int UO_R0    = 4;
  localparam int UO_G0    = 5;
  localparam int UO_B0    = 6;
  localparam int UO_HSYNC = 7;

  function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // rgb is {R1,R0,G1,G0,B1,B0}; hs/vs are already at pin level
  function automatic logic [7:0] pack_pmod(input logic [5:0] rgb, input logic hs, input logic vs);
    logic [7:0] w_word;
    w_word           = '0;
    w_word[UO_HSYNC] = hs;
    w_word[UO_B0]    = rgb[0];
    w_word[UO_G0]    = rgb[2];
    w_word[UO_R0]    = rgb[4];
    w_word[UO_VSYNC] = vs;
    w_word[UO_B1]    = rgb[1];
    w_word[UO_G1]    = rgb[3];
    w_word[UO_R1]    = rgb[5];
    return w_word;
  endfunction

endpackage

// File: rtl/vga_pmod_tx_sync.sv
// rtl/vga_pmod_tx_sync.sv - h/v raster counters with active, sync and start-pulse decode
module vga_sync_counter
  import vga_pmod_pkg::*;
#(
  parameter int   H_ACTIVE    = H_ACTIVE_DEF,
  parameter int   H_FP        = H_FP_DEF,
  parameter int   H_SYNC      = H_SYNC_DEF,
  parameter int   H_BP        = H_BP_DEF,
  parameter int   V_ACTIVE    = V_ACTIVE_DEF,
  parameter int   V_FP        = V_FP_DEF,
  parameter int   V_SYNC      = V_SYNC_DEF,
  parameter int   V_BP        = V_BP_DEF,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ena,
  output logic [CNT_W-1:0] o_h,
  output logic [CNT_W-1:0] o_v,
  output logic             o_active,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_frame_start,
  output logic             o_line_start
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;
  logic             w_in_hs;
  logic             w_in_vs;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (i_ena) begin
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  assign w_in_hs  = (r_h >= HS_BEG) && (r_h < HS_END);
  assign w_in_vs  = (r_v >= VS_BEG) && (r_v < VS_END);

  assign o_h      = r_h;
  assign o_v      = r_v;
  assign o_active = (r_h < H_ACT) && (r_v < V_ACT);
  assign o_hsync  = w_in_hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign o_vsync  = w_in_vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;

  // Pulses are gated by rst_n so the (0,0) reset state does not look like a frame start
  assign o_line_start  = i_rst_n & i_ena & (r_h == '0);
  assign o_frame_start = o_line_start & (r_v == '0);

endmodule

// File: rtl/vga_pmod_tx.sv
// rtl/vga_pmod_tx.sv - 640x480 VGA timing engine with 2-stage pixel pipeline onto TinyVGA PMOD pins
module vga_pmod_tx
  import vga_pmod_pkg::*;
#(
  parameter int   H_ACTIVE    = H_ACTIVE_DEF,
  parameter int   H_FP        = H_FP_DEF,
  parameter int   H_SYNC      = H_SYNC_DEF,
  parameter int   H_BP        = H_BP_DEF,
  parameter int   V_ACTIVE    = V_ACTIVE_DEF,
  parameter int   V_FP        = V_FP_DEF,
  parameter int   V_SYNC      = V_SYNC_DEF,
  parameter int   V_BP        = V_BP_DEF,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  output logic [CNT_W-1:0] px_x,
  output logic [CNT_W-1:0] px_y,
  output logic             px_req,
  input  logic [5:0]       px_rgb,
  output logic             frame_start,
  output logic             line_start,
  output logic [7:0]       uo_out
);

  localparam logic [7:0] UO_IDLE = pack_pmod(6'b000000, ~SYNC_ACTIVE, ~SYNC_ACTIVE);

  logic [CNT_W-1:0] w_h;
  logic [CNT_W-1:0] w_v;
  logic             w_active;
  logic             w_hsync;
  logic             w_vsync;
  logic [5:0]       w_rgb;

  logic             r_b_active;
  logic             r_b_hsync;
  logic             r_b_vsync;
  logic [7:0]       r_uo;

  vga_sync_counter #(
    .H_ACTIVE    (H_ACTIVE),
    .H_FP        (H_FP),
    .H_SYNC      (H_SYNC),
    .H_BP        (H_BP),
    .V_ACTIVE    (V_ACTIVE),
    .V_FP        (V_FP),
    .V_SYNC      (V_SYNC),
    .V_BP        (V_BP),
    .SYNC_ACTIVE (SYNC_ACTIVE)
  ) u_sync (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ena         (ena),
    .o_h           (w_h),
    .o_v           (w_v),
    .o_active      (w_active),
    .o_hsync       (w_hsync),
    .o_vsync       (w_vsync),
    .o_frame_start (frame_start),
    .o_line_start  (line_start)
  );

  assign px_req = w_active;
  assign px_x   = w_active ? w_h : '0;
  assign px_y   = w_active ? w_v : '0;

  // Source colour is only trusted for pixels that were requested one stage earlier
  assign w_rgb  = r_b_active ? px_rgb : 6'b000000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_active <= 1'b0;
      r_b_hsync  <= ~SYNC_ACTIVE;
      r_b_vsync  <= ~SYNC_ACTIVE;
      r_uo       <= UO_IDLE;
    end else if (ena) begin
      r_b_active <= w_active;
      r_b_hsync  <= w_hsync;
      r_b_vsync  <= w_vsync;
      r_uo       <= pack_pmod(w_rgb, r_b_hsync, r_b_vsync);
    end
  end

  assign uo_out = r_uo;

endmodule

// File: tb/tb_vga_pmod_tx.sv
// tb/tb_vga_pmod_tx.sv - directed bench for vga_pmod_tx with a shortened 22-line frame
module tb_vga_pmod_tx;

  localparam int HT = 800;
  localparam int VT = 22;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [9:0] px_x;
  logic [9:0] px_y;
  logic       px_req;
  logic [5:0] px_rgb;
  logic       frame_start;
  logic       line_start;
  logic [7:0] uo_out;

  int   n_vec;
  int   n_bad;
  int   cyc;
  int   bh;
  int   bv;
  logic mode;

  int         tx[4]   = '{0, 639, 0, 639};
  int         ty[4]   = '{0, 0, 15, 15};
  logic [7:0] texp[4] = '{8'h88, 8'hDD, 8'hAA, 8'hFF};

  vga_pmod_tx #(
    .V_ACTIVE (16),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .px_x        (px_x),
    .px_y        (px_y),
    .px_req      (px_req),
    .px_rgb      (px_rgb),
    .frame_start (frame_start),
    .line_start  (line_start),
    .uo_out      (uo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered upstream source sharing the advance enable
  always @(posedge clk) begin
    if (ena) px_rgb <= mode ? {px_x[1:0], px_y[1:0], px_x[3:2]} : 6'h3F;
  end

  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      bh = 0;
      bv = 0;
    end else if (ena) begin
      if (bh == HT - 1) begin
        bh = 0;
        bv = (bv == VT - 1) ? 0 : bv + 1;
      end else begin
        bh = bh + 1;
      end
    end
    #1;
    cyc = cyc + 1;
  endtask

  task automatic run_to(input int x, input int y);
    int guard;
    guard = 0;
    while (!(bh == x && bv == y) && guard < 30000) begin
      step();
      guard = guard + 1;
    end
    if (guard >= 30000) begin
      n_vec = n_vec + 1;
      n_bad = n_bad + 1;
      $display("FAIL run_to: position (%0d,%0d) not reached, at (%0d,%0d)", x, y, bh, bv);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena   = 1'b1;
    mode  = 1'b0;
    bh    = 0;
    bv    = 0;
    repeat (3) step();
    n_vec = n_vec + 1;
    if (uo_out !== 8'h88) begin n_bad = n_bad + 1; $display("FAIL reset_uo: got %h want 88", uo_out); end
    n_vec = n_vec + 1;
    if (px_req !== 1'b1) begin n_bad = n_bad + 1; $display("FAIL reset_px_req: got %b want 1", px_req); end
    n_vec = n_vec + 1;
    if (px_x !== 10'd0 || px_y !== 10'd0) begin
      n_bad = n_bad + 1; $display("FAIL reset_px_xy: got (%0d,%0d) want (0,0)", px_x, px_y);
    end
    n_vec = n_vec + 1;
    if (frame_start !== 1'b0 || line_start !== 1'b0) begin
      n_bad = n_bad + 1; $display("FAIL reset_pulses: got fs=%b ls=%b want 0 0", frame_start, line_start);
    end
    rst_n = 1'b1;
    #1;
    cyc = 0;
    n_vec = n_vec + 1;
    if (frame_start !== 1'b1 || line_start !== 1'b1) begin
      n_bad = n_bad + 1; $display("FAIL release_pulses: got fs=%b ls=%b want 1 1", frame_start, line_start);
    end
  endtask

  task automatic test_active_colour();
    logic [7:0] e_uo;
    for (int k = 0; k < HT; k++) begin
      if (cyc >= 2 && cyc <= 641)        e_uo = 8'hFF;
      else if (cyc >= 658 && cyc <= 753) e_uo = 8'h08;
      else                               e_uo = 8'h88;
      n_vec = n_vec + 1;
      if (uo_out !== e_uo) begin n_bad = n_bad + 1; $display("FAIL line0_uo c=%0d: got %h want %h", cyc, uo_out, e_uo); end
      n_vec = n_vec + 1;
      if (px_req !== (cyc < 640)) begin n_bad = n_bad + 1; $display("FAIL line0_req c=%0d: got %b", cyc, px_req); end
      n_vec = n_vec + 1;
      if (px_x !== ((cyc < 640) ? 10'(cyc) : 10'd0) || px_y !== 10'd0) begin
        n_bad = n_bad + 1; $display("FAIL line0_xy c=%0d: got (%0d,%0d)", cyc, px_x, px_y);
      end
      n_vec = n_vec + 1;
      if (line_start !== (cyc == 0) || frame_start !== (cyc == 0)) begin
        n_bad = n_bad + 1; $display("FAIL line0_pulse c=%0d: got fs=%b ls=%b", cyc, frame_start, line_start);
      end
      step();
    end
    n_vec = n_vec + 1;
    if ({line_start, frame_start, px_x, px_y} !== {1'b1, 1'b0, 10'd0, 10'd1}) begin
      n_bad = n_bad + 1;
      $display("FAIL line1_start: got ls=%b fs=%b (%0d,%0d) want 1 0 (0,1)", line_start, frame_start, px_x, px_y);
    end
  endtask

  task automatic test_frame();
    int p, ph, pv, hs_low, vs_low, vs_first, uo_err;
    logic col, hs, vs;
    logic [7:0] e_uo;
    hs_low = 0; vs_low = 0; vs_first = -1; uo_err = 0;
    while (1) begin
      p   = cyc - 2;
      ph  = p % HT;
      pv  = p / HT;
      col = (ph < 640) && (pv < 16);
      hs  = !(ph >= 656 && ph < 752);
      vs  = !(pv >= 18 && pv < 20);
      e_uo = {hs, col, col, col, vs, col, col, col};
      if (uo_out !== e_uo) uo_err = uo_err + 1;
      if (uo_out[7] === 1'b0) hs_low = hs_low + 1;
      if (uo_out[3] === 1'b0) begin
        vs_low = vs_low + 1;
        if (vs_first < 0) vs_first = cyc;
      end
      step();
      if (frame_start === 1'b1 || cyc >= 20000) break;
    end
    n_vec = n_vec + 1;
    if (cyc != 17600) begin n_bad = n_bad + 1; $display("FAIL frame_period: got %0d want 17600", cyc); end
    n_vec = n_vec + 1;
    if (vs_low != 1600) begin n_bad = n_bad + 1; $display("FAIL vsync_len: got %0d want 1600", vs_low); end
    n_vec = n_vec + 1;
    if (vs_first != 14402) begin n_bad = n_bad + 1; $display("FAIL vsync_start: got %0d want 14402", vs_first); end
    n_vec = n_vec + 1;
    if (hs_low != 2016) begin n_bad = n_bad + 1; $display("FAIL hsync_total: got %0d want 2016", hs_low); end
    n_vec = n_vec + 1;
    if (uo_err != 0) begin n_bad = n_bad + 1; $display("FAIL frame_uo: got %0d bad cycles want 0", uo_err); end
    n_vec = n_vec + 1;
    if ({px_req, px_x, px_y} !== {1'b1, 10'd0, 10'd0}) begin
      n_bad = n_bad + 1; $display("FAIL wrap_origin: got req=%b (%0d,%0d) want 1 (0,0)", px_req, px_x, px_y);
    end
    mode = 1'b1;
  endtask

  task automatic test_pixel_map(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      run_to(tx[i], ty[i]);
      n_vec = n_vec + 1;
      if (px_x !== 10'(tx[i]) || px_y !== 10'(ty[i])) begin
        n_bad = n_bad + 1; $display("FAIL map_pos %0d: got (%0d,%0d) want (%0d,%0d)", i, px_x, px_y, tx[i], ty[i]);
      end
      step();
      step();
      n_vec = n_vec + 1;
      if (uo_out !== texp[i]) begin
        n_bad = n_bad + 1; $display("FAIL map_uo (%0d,%0d): got %h want %h", tx[i], ty[i], uo_out, texp[i]);
      end
    end
  endtask

  task automatic test_freeze();
    run_to(300, 6);
    n_vec = n_vec + 1;
    if ({px_x, px_y, uo_out} !== {10'd300, 10'd6, 8'h8F}) begin
      n_bad = n_bad + 1; $display("FAIL freeze_entry: got (%0d,%0d) uo=%h want (300,6) uo=8f", px_x, px_y, uo_out);
    end
    ena = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      n_vec = n_vec + 1;
      if ({px_x, px_y, uo_out, line_start, frame_start} !== {10'd300, 10'd6, 8'h8F, 2'b00}) begin
        n_bad = n_bad + 1;
        $display("FAIL freeze_hold k=%0d: got (%0d,%0d) uo=%h ls=%b fs=%b", k, px_x, px_y, uo_out, line_start, frame_start);
      end
    end
    ena = 1'b1;
    step();
    n_vec = n_vec + 1;
    if ({px_x, px_y, uo_out} !== {10'd301, 10'd6, 8'h9F}) begin
      n_bad = n_bad + 1; $display("FAIL freeze_resume1: got (%0d,%0d) uo=%h want (301,6) uo=9f", px_x, px_y, uo_out);
    end
    step();
    n_vec = n_vec + 1;
    if (uo_out !== 8'hCE) begin n_bad = n_bad + 1; $display("FAIL freeze_resume2: got %h want ce", uo_out); end
  endtask

  task automatic test_reset_mid_frame();
    run_to(400, 8);
    rst_n = 1'b0;
    #1;
    n_vec = n_vec + 1;
    if ({uo_out, px_x, px_y, px_req, frame_start, line_start} !== {8'h88, 10'd0, 10'd0, 3'b100}) begin
      n_bad = n_bad + 1;
      $display("FAIL async_reset: got uo=%h (%0d,%0d) req=%b fs=%b ls=%b", uo_out, px_x, px_y, px_req, frame_start, line_start);
    end
    bh = 0;
    bv = 0;
    repeat (3) step();
    rst_n = 1'b1;
    #1;
    n_vec = n_vec + 1;
    if (frame_start !== 1'b1) begin n_bad = n_bad + 1; $display("FAIL restart_fs: got %b want 1", frame_start); end
    step();
    n_vec = n_vec + 1;
    if ({px_x, px_y, uo_out, frame_start} !== {10'd1, 10'd0, 8'h88, 1'b0}) begin
      n_bad = n_bad + 1; $display("FAIL restart_c1: got (%0d,%0d) uo=%h fs=%b", px_x, px_y, uo_out, frame_start);
    end
    step();
    n_vec = n_vec + 1;
    if (uo_out !== 8'h88) begin n_bad = n_bad + 1; $display("FAIL restart_px0: got %h want 88", uo_out); end
    step();
    n_vec = n_vec + 1;
    if (uo_out !== 8'h98) begin n_bad = n_bad + 1; $display("FAIL restart_px1: got %h want 98", uo_out); end
  endtask

  initial begin
    n_vec  = 0;
    n_bad  = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    mode   = 1'b0;
    px_rgb = 6'h00;
    test_reset();
    test_active_colour();
    test_frame();
    test_pixel_map(0, 1);
    test_freeze();
    test_reset_mid_frame();
    test_pixel_map(2, 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
